// File: rtl/inst_prefetch_if.sv
// Memory read bus between the instruction prefetcher (master) and program memory (slave).
// One outstanding request; address and request held until the ack.
`timescale 1ns/1ps
interface inst_prefetch_if #(
   parameter int ADDR_W = 16
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [7:0]        mem_rdata;

   modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
   modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: fills a circular byte queue from program memory and presents
// opcode plus two following bytes to the decoder; flush redirects without breaking the bus.
//
//   state   | meaning
//   IDLE    | no request on the bus; queue full or waiting for room
//   REQ     | fetching byte at fetch_pc; pushes on ack
//   DISCARD | request from before a flush still in flight; its data is dropped
`timescale 1ns/1ps
module inst_prefetch #(
   parameter int              DEPTH      = 16,
   parameter int              ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] RESET_ADDR = 16'hFFFC
) (
   input  logic                     clk,
   input  logic                     rst_n,
   inst_prefetch_if.master          mem,
   input  logic                     flush,
   input  logic [ADDR_W-1:0]        flush_addr,
   input  logic [1:0]               dec_len,
   input  logic                     dec_take,
   output logic                     out_op_valid,
   output logic                     out_valid,
   output logic [7:0]               out_op,
   output logic [7:0]               out_opr0,
   output logic [7:0]               out_opr1,
   output logic [ADDR_W-1:0]        out_pc,
   output logic [$clog2(DEPTH):0]   q_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t            state;
   logic [7:0]        queue [DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     count;
   logic [ADDR_W-1:0] fetch_pc;

   logic [1:0]        len_eff;
   logic              push;
   logic              pop;
   logic [CW-1:0]     pop_len;
   logic [CW-1:0]     count_next;
   logic              room;

   always_comb begin
      len_eff      = (dec_len == 2'd0) ? 2'd1 : dec_len;
      out_op_valid = (count != '0);
      out_valid    = (count >= CW'(len_eff));
      out_op       = (count >= CW'(1)) ? queue[head]            : 8'h00;
      out_opr0     = (count >= CW'(2)) ? queue[head + PW'(1)]   : 8'h00;
      out_opr1     = (count >= CW'(3)) ? queue[head + PW'(2)]   : 8'h00;
      push         = (state == REQ) && mem.mem_ack && !flush;
      pop          = dec_take && out_valid && !flush;
      pop_len      = pop ? CW'(len_eff) : '0;
      count_next   = count + CW'(push) - pop_len;
      room         = (count_next < CW'(DEPTH));
   end

   assign q_count = count;

   // storage needs no reset: bytes are only visible once counted
   always_ff @(posedge clk) begin
      if (push) queue[tail] <= mem.mem_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         mem.mem_req  <= 1'b0;
         mem.mem_addr <= '0;
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         fetch_pc     <= RESET_ADDR;
         out_pc       <= RESET_ADDR;
      end else begin
         if (flush) begin
            count    <= '0;
            head     <= tail;
            out_pc   <= flush_addr;
            fetch_pc <= flush_addr;
         end else begin
            count <= count_next;
            if (push) begin
               tail     <= tail + PW'(1);
               fetch_pc <= fetch_pc + 1'b1;
            end
            if (pop) begin
               head   <= head + PW'(len_eff);
               out_pc <= out_pc + ADDR_W'(len_eff);
            end
         end

         case (state)
            IDLE: begin
               if (flush) begin
                  state        <= REQ;
                  mem.mem_req  <= 1'b1;
                  mem.mem_addr <= flush_addr;
               end else if (room) begin
                  state        <= REQ;
                  mem.mem_req  <= 1'b1;
                  mem.mem_addr <= fetch_pc;
               end
            end
            REQ: begin
               if (mem.mem_ack) begin
                  if (flush) begin
                     mem.mem_addr <= flush_addr;
                  end else if (room) begin
                     mem.mem_addr <= fetch_pc + 1'b1;
                  end else begin
                     state       <= IDLE;
                     mem.mem_req <= 1'b0;
                  end
               end else if (flush) begin
                  // the bus cycle must complete untouched; its byte is stale
                  state <= DISCARD;
               end
            end
            DISCARD: begin
               if (mem.mem_ack) begin
                  state        <= REQ;
                  mem.mem_addr <= flush ? flush_addr : fetch_pc;
               end
            end
            default: begin
               state       <= IDLE;
               mem.mem_req <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: reset, streaming, saturation, partial instruction,
// flush corner cases, then a short randomized run against a byte-queue reference model.
`timescale 1ns/1ps
module tb_inst_prefetch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush;
   logic [15:0] flush_addr;
   logic [1:0]  dec_len;
   logic        dec_take;
   logic        out_op_valid;
   logic        out_valid;
   logic [7:0]  out_op;
   logic [7:0]  out_opr0;
   logic [7:0]  out_opr1;
   logic [15:0] out_pc;
   logic [4:0]  q_count;

   int total = 0;
   int bad   = 0;
   int mem_wait = 0;
   bit mem_en   = 1'b1;
   int wcnt     = 0;

   logic [7:0]  m_q [$];
   logic [15:0] m_pc;
   bit          m_disc;

   always #5 clk = ~clk;

   inst_prefetch_if #(.ADDR_W(16)) bus ();

   inst_prefetch #(.DEPTH(16), .ADDR_W(16), .RESET_ADDR(16'hFFFC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem          (bus),
      .flush        (flush),
      .flush_addr   (flush_addr),
      .dec_len      (dec_len),
      .dec_take     (dec_take),
      .out_op_valid (out_op_valid),
      .out_valid    (out_valid),
      .out_op       (out_op),
      .out_opr0     (out_opr0),
      .out_opr1     (out_opr1),
      .out_pc       (out_pc),
      .q_count      (q_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // memory: answers mem_addr[7:0] after mem_wait idle cycles, decided just after each edge
   initial begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n || !bus.mem_req || !mem_en) begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
         end else if (wcnt >= mem_wait) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = bus.mem_addr[7:0];
            wcnt = 0;
         end else begin
            bus.mem_ack = 1'b0;
            wcnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int len;
      flush      = 1'b0;
      flush_addr = 16'h0000;
      dec_len    = 2'd3;
      dec_take   = 1'b0;

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_req",    32'(bus.mem_req), 32'h0);
      chk("rst_addr",   32'(bus.mem_addr), 32'h0);
      chk("rst_count",  32'(q_count), 32'h0);
      chk("rst_pc",     32'(out_pc), 32'hFFFC);
      chk("rst_op",     32'(out_op), 32'h0);
      chk("rst_opv",    32'(out_op_valid), 32'h0);
      chk("rst_valid",  32'(out_valid), 32'h0);

      // streaming from reset address
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_req",  32'(bus.mem_req), 32'h1);
      chk("first_addr", 32'(bus.mem_addr), 32'hFFFC);
      @(negedge clk);
      chk("addr_fffd",  32'(bus.mem_addr), 32'hFFFD);
      chk("cnt1",       32'(q_count), 32'h1);
      chk("op_fc",      32'(out_op), 32'hFC);
      chk("valid_len3_cnt1", 32'(out_valid), 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("addr_ffff",  32'(bus.mem_addr), 32'hFFFF);
      chk("cnt3",       32'(q_count), 32'h3);
      chk("op3",        32'(out_op), 32'hFC);
      chk("opr0_3",     32'(out_opr0), 32'hFD);
      chk("opr1_3",     32'(out_opr1), 32'hFE);
      chk("pc3",        32'(out_pc), 32'hFFFC);
      chk("valid_len3_cnt3", 32'(out_valid), 32'h1);
      @(negedge clk);
      chk("addr_wrap",  32'(bus.mem_addr), 32'h0000);

      // saturation
      for (int i = 0; i < 30 && q_count != 5'd16; i++) @(negedge clk);
      chk("sat_count",  32'(q_count), 32'd16);
      @(negedge clk);
      chk("sat_hold",   32'(q_count), 32'd16);
      chk("sat_noreq",  32'(bus.mem_req), 32'h0);
      chk("sat_op",     32'(out_op), 32'hFC);

      dec_len  = 2'd3;
      dec_take = 1'b1;
      @(negedge clk);
      dec_take = 1'b0;
      chk("pop3_count", 32'(q_count), 32'd13);
      chk("pop3_pc",    32'(out_pc), 32'hFFFF);
      chk("pop3_op",    32'(out_op), 32'hFF);
      chk("pop3_opr1",  32'(out_opr1), 32'h01);
      chk("resume_req", 32'(bus.mem_req), 32'h1);
      chk("resume_addr",32'(bus.mem_addr), 32'h000C);

      // flush coincident with ack and a legal take
      flush      = 1'b1;
      flush_addr = 16'h0135;
      dec_take   = 1'b1;
      dec_len    = 2'd1;
      mem_en     = 1'b0;
      @(negedge clk);
      flush    = 1'b0;
      dec_take = 1'b0;
      chk("fack_count", 32'(q_count), 32'h0);
      chk("fack_addr",  32'(bus.mem_addr), 32'h0135);
      chk("fack_pc",    32'(out_pc), 32'h0135);
      chk("fack_req",   32'(bus.mem_req), 32'h1);
      chk("fack_opv",   32'(out_op_valid), 32'h0);

      // single byte held, instruction needs two
      mem_en = 1'b1;
      @(negedge clk);
      mem_en = 1'b0;
      @(negedge clk);
      dec_len = 2'd2;
      #1;
      chk("part_count", 32'(q_count), 32'h1);
      chk("part_op",    32'(out_op), 32'h35);
      chk("part_opv",   32'(out_op_valid), 32'h1);
      chk("part_valid", 32'(out_valid), 32'h0);
      chk("part_opr0",  32'(out_opr0), 32'h00);
      chk("part_addr",  32'(bus.mem_addr), 32'h0136);
      dec_take = 1'b1;
      @(negedge clk);
      dec_take = 1'b0;
      chk("part_take_ignored", 32'(q_count), 32'h1);
      chk("part_take_pc",      32'(out_pc), 32'h0135);
      dec_len = 2'd0;
      #1;
      chk("len0_as_1",  32'(out_valid), 32'h1);

      // flush during a slow bus cycle
      dec_len  = 2'd1;
      mem_wait = 3;
      mem_en   = 1'b1;
      @(negedge clk);
      flush      = 1'b1;
      flush_addr = 16'h0200;
      @(negedge clk);
      flush = 1'b0;
      chk("disc_req",   32'(bus.mem_req), 32'h1);
      chk("disc_addr",  32'(bus.mem_addr), 32'h0136);
      chk("disc_count", 32'(q_count), 32'h0);
      chk("disc_pc",    32'(out_pc), 32'h0200);
      n = 0;
      while (n < 10 && bus.mem_addr != 16'h0200) begin
         @(negedge clk);
         n++;
      end
      chk("disc_lat",   32'(n), 32'd3);
      chk("disc_newaddr", 32'(bus.mem_addr), 32'h0200);
      chk("disc_dropped", 32'(q_count), 32'h0);

      // refill from 0x0200 then random traffic against the model
      mem_wait = 0;
      for (int i = 0; i < 60 && q_count != 5'd16; i++) @(negedge clk);
      chk("refill_count", 32'(q_count), 32'd16);
      m_q.delete();
      for (int i = 0; i < 16; i++) m_q.push_back(8'(i));
      m_pc   = 16'h0200;
      m_disc = 1'b0;

      for (int c = 0; c < 40; c++) begin
         chk("rnd_count", 32'(q_count), 32'(m_q.size()));
         chk("rnd_op",    32'(out_op),   32'((m_q.size() >= 1) ? m_q[0] : 8'h00));
         chk("rnd_opr0",  32'(out_opr0), 32'((m_q.size() >= 2) ? m_q[1] : 8'h00));
         chk("rnd_opr1",  32'(out_opr1), 32'((m_q.size() >= 3) ? m_q[2] : 8'h00));
         chk("rnd_pc",    32'(out_pc),   32'(m_pc));
         dec_take   = 1'($urandom_range(0, 1));
         dec_len    = 2'($urandom_range(0, 3));
         flush      = ($urandom_range(0, 15) == 0);
         flush_addr = 16'($urandom);
         mem_wait   = int'($urandom_range(0, 1));
         #1;
         len = (dec_len == 2'd0) ? 1 : int'(dec_len);
         if (flush) begin
            m_q.delete();
            m_pc = flush_addr;
         end else if (dec_take && m_q.size() >= len) begin
            repeat (len) void'(m_q.pop_front());
            m_pc = m_pc + 16'(len);
         end
         if (bus.mem_req && bus.mem_ack) begin
            if (!m_disc && !flush) m_q.push_back(bus.mem_rdata);
            m_disc = 1'b0;
         end
         if (flush && bus.mem_req && !bus.mem_ack) m_disc = 1'b1;
         @(negedge clk);
      end
      flush    = 1'b0;
      dec_take = 1'b0;
      chk("final_count", 32'(q_count), 32'(m_q.size()));
      chk("final_pc",    32'(out_pc),  32'(m_pc));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
